// File: rtl/dq_pkg.sv
// Shared types and default sizing for the dequantizer request scheduler.
package dq_pkg;

    localparam int DQ_LAT_DEF     = 6;
    localparam int FIFO_DEPTH_DEF = 8;
    // Widest requester tag a tracking entry can carry; narrower tags are zero-extended.
    localparam int DQ_TAG_W_MAX   = 16;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        logic                    valid;
        logic                    is_weight;
        logic [DQ_TAG_W_MAX-1:0] tag;
    } trk_t;

endpackage

// File: rtl/dq_sched_fifo.sv
// Synchronous first-word-fall-through result buffer, head visible whenever non-empty.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none internally; the caller never pushes when full nor pops when empty.
module dq_sched_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (cnt == '0);

endmodule

// File: rtl/dq_sched.sv
// Credit-gated W/A request scheduler for the dequantizer; DQ_SCHED_STRICT_PRIO_EN selects weight-first priority.
// Latency: issue to out_valid is DQ_LAT+1 cycles with the buffer empty.
// Backpressure: issue stalls once in-flight plus buffered results reach FIFO_DEPTH, unless a pop frees a slot that cycle.
module dq_sched
    import dq_pkg::*;
#(
    parameter int DQ_LAT     = DQ_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [31:0]      w_level,
    input  logic [TAG_W-1:0] w_tag,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_level,
    input  logic [TAG_W-1:0] a_tag,
    output logic [31:0]      dq_level_int,
    output logic             dq_is_weight,
    input  logic [31:0]      dq_weight_fp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_is_weight,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CRED = CW'(FIFO_DEPTH);

    typedef struct packed {
        fp32_t            data;
        logic             is_weight;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam int RES_W = $bits(res_t);

    logic [CW-1:0] credits;
    logic          pop;
    logic          issue_ok;
    logic          grant_w;
    logic          grant_a;
    logic          issue;
    logic          issue_w;
    trk_t          trk [DQ_LAT];
    trk_t          trk_in;
    logic          trk_any;
    res_t          push_ent;
    res_t          head_ent;
    logic          fifo_empty;

    assign pop = out_valid && out_ready;

    // A pop at full credit frees its slot in time for a same-cycle issue.
    assign issue_ok = rst && ((credits < FULL_CRED) || ((credits == FULL_CRED) && pop));

`ifdef DQ_SCHED_STRICT_PRIO_EN
    assign grant_w = w_valid;
    assign grant_a = a_valid && !w_valid;
`else
    logic prefer_w;

    assign grant_w = w_valid && (!a_valid || prefer_w);
    assign grant_a = a_valid && !grant_w;

    always_ff @(posedge clk) begin
        if (!rst)
            prefer_w <= 1'b1;
        else if (issue)
            prefer_w <= !issue_w;
    end
`endif

    assign w_ready      = issue_ok && grant_w;
    assign a_ready      = issue_ok && grant_a;
    assign issue_w      = w_valid && w_ready;
    assign issue        = issue_w || (a_valid && a_ready);
    assign dq_is_weight = issue_w;

    always_comb begin
        dq_level_int = '0;
        trk_in       = '0;
        if (issue_w) begin
            dq_level_int = w_level;
            trk_in.tag   = DQ_TAG_W_MAX'(w_tag);
        end else if (issue) begin
            dq_level_int = a_level;
            trk_in.tag   = DQ_TAG_W_MAX'(a_tag);
        end
        trk_in.valid     = issue;
        trk_in.is_weight = issue_w;
    end

    // Stage DQ_LAT-1 lines up with the datapath returning that issue's result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DQ_LAT; i++) trk[i] <= '0;
        end else begin
            trk[0] <= trk_in;
            for (int i = 1; i < DQ_LAT; i++) trk[i] <= trk[i-1];
        end
    end

    always_comb begin
        trk_any = 1'b0;
        for (int i = 0; i < DQ_LAT; i++) trk_any = trk_any | trk[i].valid;
    end

    // Credits cover in-flight plus buffered results; a push only moves one between the two.
    always_ff @(posedge clk) begin
        if (!rst)
            credits <= '0;
        else if (issue && !pop)
            credits <= credits + CW'(1);
        else if (pop && !issue)
            credits <= credits - CW'(1);
    end

    always_comb begin
        push_ent           = '0;
        push_ent.data      = dq_weight_fp;
        push_ent.is_weight = trk[DQ_LAT-1].is_weight;
        push_ent.tag       = TAG_W'(trk[DQ_LAT-1].tag);
    end

    dq_sched_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (trk[DQ_LAT-1].valid),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .empty    (fifo_empty)
    );

    assign out_valid     = rst && !fifo_empty;
    assign out_data      = out_valid ? head_ent.data : '0;
    assign out_is_weight = out_valid && head_ent.is_weight;
    assign out_tag       = out_valid ? head_ent.tag : '0;
    assign busy          = rst && (trk_any || !fifo_empty);

endmodule

// File: tb/tb_dq_sched.sv
// Bench for dq_sched: queue-based reference model of credits, arbitration and result order,
// plus a behavioural dequantizer pipeline on the dq_* side.
module tb_dq_sched;

    localparam int DQ_LAT = 6;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             w_valid, w_ready, a_valid, a_ready;
    logic [31:0]      w_level, a_level;
    logic [TAG_W-1:0] w_tag, a_tag;
    logic [31:0]      dq_level_int;
    logic             dq_is_weight;
    logic [31:0]      dq_weight_fp;
    logic             out_valid, out_ready, out_is_weight, busy;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    dq_sched #(.DQ_LAT(DQ_LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_level(w_level), .w_tag(w_tag),
        .a_valid(a_valid), .a_ready(a_ready), .a_level(a_level), .a_tag(a_tag),
        .dq_level_int(dq_level_int), .dq_is_weight(dq_is_weight), .dq_weight_fp(dq_weight_fp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_weight(out_is_weight), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dq_model(input logic [31:0] lvl, input logic w);
        return (lvl * 32'd3) ^ (w ? 32'h3F80_0000 : 32'h4000_0000);
    endfunction

    logic [31:0] dq_pipe [DQ_LAT];
    always @(posedge clk) begin
        dq_pipe[0] <= dq_model(dq_level_int, dq_is_weight);
        for (int i = 1; i < DQ_LAT; i++) dq_pipe[i] <= dq_pipe[i-1];
    end
    assign dq_weight_fp = dq_pipe[DQ_LAT-1];

    typedef struct packed {
        logic [31:0]      data;
        logic             is_w;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_fifo[$];
    exp_t infl[$];
    int   infl_due[$];
    bit   prefer_w = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    // One clock of stimulus: compare against the model, advance the model, return at the next negedge.
    task automatic run_cycle();
        bit    pop_now, allowed, gw, ga, iss, iss_w, exp_busy;
        int    credits;
        logic [31:0] exp_lvl;
        exp_t  r;
        #1;
        if (!rst) begin
            n_total++;
            if ({w_ready, a_ready, out_valid, busy, out_is_weight, dq_is_weight} !== 6'b0 ||
                out_data !== 32'h0 || out_tag !== '0 || dq_level_int !== 32'h0)
                $display("FAIL in_reset cyc=%0d got wr=%b ar=%b ov=%b busy=%b od=%h ot=%h dq=%h, need all 0",
                         cyc, w_ready, a_ready, out_valid, busy, out_data, out_tag, dq_level_int);
            else n_pass++;
            @(posedge clk);
            exp_fifo.delete(); infl.delete(); infl_due.delete();
            prefer_w = 1'b1;
            cyc++;
            @(negedge clk);
            return;
        end
        pop_now = (exp_fifo.size() > 0) && out_ready;
        credits = infl.size() + exp_fifo.size();
        allowed = (credits < DEPTH) || (credits == DEPTH && pop_now);
`ifdef DQ_SCHED_STRICT_PRIO_EN
        gw = w_valid;
        ga = a_valid && !w_valid;
`else
        gw = w_valid && (!a_valid || prefer_w);
        ga = a_valid && !gw;
`endif
        iss_w = allowed && gw;
        iss   = iss_w || (allowed && ga);
        n_total++;
        if ({w_ready, a_ready} !== {iss_w, allowed && ga})
            $display("FAIL ready cyc=%0d got w=%b a=%b need w=%b a=%b", cyc, w_ready, a_ready, iss_w, allowed && ga);
        else n_pass++;
        exp_lvl = iss_w ? w_level : (iss ? a_level : 32'h0);
        n_total++;
        if ({dq_level_int, dq_is_weight} !== {exp_lvl, iss_w})
            $display("FAIL dq_drive cyc=%0d got %h/%b need %h/%b", cyc, dq_level_int, dq_is_weight, exp_lvl, iss_w);
        else n_pass++;
        n_total++;
        if (out_valid !== (exp_fifo.size() > 0))
            $display("FAIL out_valid cyc=%0d got %b need %b", cyc, out_valid, exp_fifo.size() > 0);
        else n_pass++;
        if (exp_fifo.size() > 0) begin
            n_total++;
            if ({out_data, out_is_weight, out_tag} !== {exp_fifo[0].data, exp_fifo[0].is_w, exp_fifo[0].tag})
                $display("FAIL out_head cyc=%0d got %h/%b/%h need %h/%b/%h", cyc, out_data, out_is_weight,
                         out_tag, exp_fifo[0].data, exp_fifo[0].is_w, exp_fifo[0].tag);
            else n_pass++;
        end
        exp_busy = (infl.size() > 0) || (exp_fifo.size() > 0);
        n_total++;
        if (busy !== exp_busy)
            $display("FAIL busy cyc=%0d got %b need %b", cyc, busy, exp_busy);
        else n_pass++;
        n_total++;
        if (int'(dut.u_fifo.cnt) !== exp_fifo.size())
            $display("FAIL occupancy cyc=%0d got %0d need %0d", cyc, dut.u_fifo.cnt, exp_fifo.size());
        else n_pass++;
        if (iss) begin
            r.data = dq_model(exp_lvl, iss_w);
            r.is_w = iss_w;
            r.tag  = iss_w ? w_tag : a_tag;
            infl.push_back(r);
            infl_due.push_back(cyc + DQ_LAT + 1);
            prefer_w = !iss_w;
        end
        if (pop_now) void'(exp_fifo.pop_front());
        @(posedge clk);
        cyc++;
        while (infl.size() > 0 && infl_due[0] == cyc) begin
            n_total++;
            if (exp_fifo.size() >= DEPTH)
                $display("FAIL overflow cyc=%0d push into occupancy %0d", cyc, exp_fifo.size());
            else n_pass++;
            exp_fifo.push_back(infl.pop_front());
            void'(infl_due.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int k;
        w_valid = 1'b0; a_valid = 1'b0; out_ready = 1'b1; k = 0;
        while (busy && k < 60) begin run_cycle(); k++; end
        n_total++;
        if (busy !== 1'b0) $display("FAIL drain_timeout busy=%b need 0 after %0d cycles", busy, k);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; w_valid = 1'b1; a_valid = 1'b1; out_ready = 1'b1;
        w_level = 32'h1234; a_level = 32'h5678;
        repeat (2) run_cycle();
        rst = 1'b1; w_valid = 1'b0; a_valid = 1'b0;
        #1;
        n_total++;
        if ({w_ready, a_ready, out_valid, busy} !== 4'b0)
            $display("FAIL reset_release got %b need 0000", {w_ready, a_ready, out_valid, busy});
        else n_pass++;
        run_cycle();
    endtask

    task automatic test_single();
        int k;
        w_valid = 1'b1; w_level = 32'h10; w_tag = 4'd3; a_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_total++;
        if (dq_is_weight !== 1'b1 || w_ready !== 1'b1)
            $display("FAIL single_issue got is_w=%b rdy=%b need 1/1", dq_is_weight, w_ready);
        else n_pass++;
        run_cycle();
        w_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 20) begin run_cycle(); k++; end
        n_total++;
        if (k != DQ_LAT + 1) $display("FAIL single_latency got %0d need %0d", k, DQ_LAT + 1);
        else n_pass++;
        n_total++;
        if (out_tag !== 4'd3 || out_is_weight !== 1'b1)
            $display("FAIL single_tag got tag=%0d w=%b need 3/1", out_tag, out_is_weight);
        else n_pass++;
        n_total++;
        if (out_data !== dq_model(32'h10, 1'b1))
            $display("FAIL single_data got %h need %h", out_data, dq_model(32'h10, 1'b1));
        else n_pass++;
        run_cycle();
    endtask

    task automatic test_rr();
        int  nres;
        int  n_req;
        bit  exp_w;
        rst = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        run_cycle();
        rst = 1'b1; out_ready = 1'b1; nres = 0;
`ifdef DQ_SCHED_STRICT_PRIO_EN
        n_req = 10;
`else
        n_req = 16;
`endif
        for (int i = 0; i < n_req + 12; i++) begin
            w_valid = (i < n_req); a_valid = (i < n_req);
            w_level = $urandom; a_level = $urandom;
            w_tag = TAG_W'(i); a_tag = TAG_W'(i);
            #1;
`ifdef DQ_SCHED_STRICT_PRIO_EN
            exp_w = 1'b1;
`else
            exp_w = (i % 2 == 0);
`endif
            if (i < n_req) begin
                n_total++;
                if ({w_ready, a_ready} !== {exp_w, !exp_w})
                    $display("FAIL rr_grant i=%0d got w=%b a=%b need w=%b a=%b", i, w_ready, a_ready, exp_w, !exp_w);
                else n_pass++;
            end
            if (out_valid) begin
`ifdef DQ_SCHED_STRICT_PRIO_EN
                exp_w = 1'b1;
`else
                exp_w = (nres % 2 == 0);
`endif
                n_total++;
                if (out_tag !== TAG_W'(nres) || out_is_weight !== exp_w)
                    $display("FAIL rr_order n=%0d got tag=%0d w=%b need tag=%0d w=%b",
                             nres, out_tag, out_is_weight, nres, exp_w);
                else n_pass++;
                nres++;
            end
            run_cycle();
        end
        n_total++;
        if (nres != n_req) $display("FAIL rr_count got %0d need %0d", nres, n_req);
        else n_pass++;
    endtask

    task automatic test_credit();
        int cnt;
        drain();
        out_ready = 1'b0; w_valid = 1'b1; a_valid = 1'b0; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            w_level = $urandom; w_tag = TAG_W'($urandom);
            #1;
            if (w_ready) cnt++;
            run_cycle();
        end
        #1;
        n_total++;
        if (cnt != DEPTH) $display("FAIL credit_issues got %0d need %0d", cnt, DEPTH);
        else n_pass++;
        n_total++;
        if (w_ready !== 1'b0) $display("FAIL credit_stall got w_ready=%b need 0", w_ready);
        else n_pass++;
        out_ready = 1'b1; cnt = 0;
        for (int i = 0; i < 16; i++) begin
            w_level = $urandom; w_tag = TAG_W'($urandom);
            #1;
            if (w_ready) cnt++;
            run_cycle();
            out_ready = 1'b0;
        end
        n_total++;
        if (cnt != 1) $display("FAIL credit_one_more got %0d need 1", cnt);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        w_valid = 1'b0; out_ready = 1'b0;
        repeat (DQ_LAT + 2) run_cycle();
        out_ready = 1'b1; w_valid = 1'b1; w_level = $urandom; w_tag = TAG_W'($urandom);
        #1;
        n_total++;
        if (w_ready !== 1'b1 || out_valid !== 1'b1 || int'(dut.u_fifo.cnt) !== DEPTH)
            $display("FAIL full_pop got rdy=%b ov=%b occ=%0d need 1/1/%0d", w_ready, out_valid, dut.u_fifo.cnt, DEPTH);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            w_level = $urandom; w_tag = TAG_W'($urandom);
            run_cycle();
        end
        drain();
    endtask

    task automatic test_mid_reset();
        int seen;
        out_ready = 1'b0; a_valid = 1'b0;
        w_valid = 1'b1;
        repeat (3) begin w_level = $urandom; w_tag = TAG_W'($urandom); run_cycle(); end
        w_valid = 1'b0;
        repeat (DQ_LAT + 1) run_cycle();
        w_valid = 1'b1;
        repeat (5) begin w_level = $urandom; w_tag = TAG_W'($urandom); run_cycle(); end
        w_valid = 1'b0;
        n_total++;
        if (int'(dut.u_fifo.cnt) !== 3 || busy !== 1'b1)
            $display("FAIL pre_reset got occ=%0d busy=%b need 3/1", dut.u_fifo.cnt, busy);
        else n_pass++;
        rst = 1'b0;
        run_cycle();
        rst = 1'b1; out_ready = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL post_reset got ov=%b busy=%b need 0/0", out_valid, busy);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            run_cycle();
        end
        n_total++;
        if (seen != 0) $display("FAIL stale_results got %0d need 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cnt;
        drain();
        out_ready = 1'b1; w_valid = 1'b1; a_valid = 1'b0; cnt = 0;
        for (int i = 0; i < 40; i++) begin
            w_level = $urandom; w_tag = TAG_W'($urandom);
            #1;
            if (i >= 10 && out_valid) cnt++;
            run_cycle();
        end
        n_total++;
        if (cnt != 30) $display("FAIL throughput got %0d need 30", cnt);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            w_valid   = ($urandom_range(0, 2) != 0);
            a_valid   = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            w_level   = $urandom; a_level = $urandom;
            w_tag     = TAG_W'($urandom); a_tag = TAG_W'($urandom);
            run_cycle();
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; w_valid = 1'b0; a_valid = 1'b0; out_ready = 1'b0;
        w_level = '0; a_level = '0; w_tag = '0; a_tag = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_rr();
        test_credit();
        test_full_pop();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dq_sched.md
DQ_SCHED -- requirements
Module: dq_sched

Interface
REQ-001 Parameter DQ_LAT, default 6: cycles from dq_level_int/dq_is_weight presentation to the matching dq_weight_fp result.
REQ-002 Parameter FIFO_DEPTH, default 8: output buffer entries, which is also the credit limit; must be a power of 2 and at least 2.
REQ-003 Parameter TAG_W, default 4: width of the requester tag.
REQ-004 clk  in  1  clock; all logic on the posedge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 w_valid / w_ready  in / out  1  weight-request handshake.
REQ-007 w_level  in  32  signed integer weight level; w_tag  in  TAG_W  weight-request tag.
REQ-008 a_valid / a_ready  in / out  1  activation-request handshake.
REQ-009 a_level  in  32  activation level; a_tag  in  TAG_W  activation-request tag.
REQ-010 dq_level_int  out  32  level driven to the dequantizer datapath.
REQ-011 dq_is_weight  out  1  qstep select driven to the dequantizer datapath.
REQ-012 dq_weight_fp  in  32  FP32 result returned by the dequantizer datapath.
REQ-013 out_valid / out_ready  out / in  1  result handshake.
REQ-014 out_data  out  32  FP32 result; out_is_weight  out  1  result source; out_tag  out  TAG_W  result tag.
REQ-015 busy  out  1  high while any request is in flight or buffered.

Function
REQ-016 At most one request issues per cycle; a request transfers when valid && ready.
REQ-017 credits_used = in-flight count + FIFO occupancy; issue is allowed only when credits_used < FIFO_DEPTH, or when credits_used == FIFO_DEPTH and an output pop occurs in the same cycle.
REQ-018 w_ready and a_ready are combinational from grant and credit state; at most one is high per cycle, and neither is high when issue is not allowed.
REQ-019 Default arbitration is round-robin: when both requesters are valid, grant the one not served last; a lone valid requester is granted; after reset, weight wins the first tie.
REQ-020 On issue, drive dq_level_int and dq_is_weight combinationally in that same cycle; when idle, drive both as 0.
REQ-021 A DQ_LAT-deep tracking shift register carries {valid, is_weight, tag} for each issue.
REQ-022 When the last tracking stage is valid, push {dq_weight_fp, is_weight, tag} into the FIFO in that cycle.
REQ-023 FIFO overflow is impossible by the REQ-017 credit rule; the bench asserts a push never occurs when the FIFO is full.
REQ-024 out_valid = FIFO non-empty; out_data, out_is_weight and out_tag are the FIFO head, held stable while out_valid && !out_ready.
REQ-025 A push and a pop in the same cycle leave occupancy unchanged; a push into an empty FIFO makes out_valid high the next cycle.
REQ-026 Results leave in issue order; latency from issue to out_valid is DQ_LAT+1 cycles with the FIFO empty.
REQ-027 Sustained throughput is one result per cycle when out_ready is held at 1.
REQ-028 busy = any tracking stage valid || FIFO non-empty.

Reset
REQ-029 While rst=0, clear: tracking register, FIFO pointers and occupancy, credit counters, round-robin pointer (weight wins next tie).
REQ-030 While rst=0: w_ready=a_ready=0, out_valid=0, busy=0, out_data/out_is_weight/out_tag=0, dq_level_int=0, dq_is_weight=0.
REQ-031 Reset mid-operation discards all in-flight and buffered results; dq_weight_fp values arriving after reset release are ignored.

Configuration
REQ-032 With DQ_SCHED_STRICT_PRIO_EN defined, weight requests have strict priority over activation requests, and the round-robin pointer is absent.
REQ-033 Without DQ_SCHED_STRICT_PRIO_EN, arbitration is round-robin per REQ-019.

Structure
REQ-034 Shared package dq_pkg holds the 32-bit FP32 word type, the tracking-entry struct {valid, is_weight, tag}, and the default DQ_LAT/FIFO_DEPTH constants.
REQ-035 The output buffer is one sub-module, dq_sched_fifo (synchronous, first-word-fall-through, parameterised on width and depth); arbitration, credits and tracking stay in dq_sched.

Verification
REQ-036 Single weight request, level 0x00000010, tag 3, out_ready=1 -> dq_is_weight=1 in the issue cycle; out_valid exactly 7 cycles later with tag 3, out_is_weight=1, data equal to the model's dq_weight_fp.
REQ-037 Both requesters continuously valid, no strict-prio macro -> grants W,A,W,A...; 16 results return in issue order with matching tags.
REQ-038 out_ready=0, weight valid continuously -> exactly 8 issues, then w_ready=0; one pop -> exactly one further issue.
REQ-039 Same-cycle pop at full credit with a request valid -> issue proceeds; FIFO occupancy stays at 8; no overflow assertion fires.
REQ-040 rst=0 for 1 cycle with 5 requests in flight and 3 buffered -> out_valid=0 and busy=0 after reset; no stale results are emitted.
REQ-041 With DQ_SCHED_STRICT_PRIO_EN defined and both requesters valid for 10 cycles -> all 10 grants go to weight.
